aes_stream_sched: RTL

- Sequencing controller for the AES-256 encrypt datapath between the AXI DMA MM2S and S2MM streams.
- Issues input beats into the fixed-latency AES pipeline under credit-based flow control, so the result FIFO can never overflow.
- Tracks beat valid/last through the pipeline latency and generates the result-FIFO write strobe.
- Owns the result-FIFO pop and sequences the per-packet S2MM status stream after each packet's last data beat.

---
 rtl/aes_sched_pkg.sv | 14 +
 rtl/aes_lat_pipe.sv | 38 +++
 rtl/aes_stream_sched.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the AES stream scheduler.
// Holds the output FSM encoding and the status-word layout.
package aes_sched_pkg;

    typedef enum logic {
        ST_DATA = 1'b0,
        ST_STS  = 1'b1
    } sched_state_t;

    localparam logic [31:0] STS_WORD0  = 32'h5000_0000;
    localparam int          STS_NWORDS = 5;
    localparam int          STS_IDX_W  = 3;

endpackage

// File: rtl/aes_lat_pipe.sv
// Fixed-depth delay line tracking beat flags through the AES pipeline.
// Ports: clk, rst (async high), d in, q out after LAT cycles, any = some stage set.
module aes_lat_pipe #(
    parameter int W   = 2,
    parameter int LAT = 30
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         any
);

    logic [W-1:0] sr_q [LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                sr_q[i] <= '0;
            end
        end else begin
            sr_q[0] <= d;
            for (int i = 1; i < LAT; i++) begin
                sr_q[i] <= sr_q[i-1];
            end
        end
    end

    assign q = sr_q[LAT-1];

    always_comb begin
        any = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            any = any | (|sr_q[i]);
        end
    end

endmodule

// File: rtl/aes_stream_sched.sv
// Credit-based issue, latency tracking, result pop and S2MM status sequencing.
// Ports: MM2S in_*, issue strobe, res_* FIFO write, rf_* FIFO head/pop, s2mm/sts streams, busy.
module aes_stream_sched
    import aes_sched_pkg::*;
#(
    parameter int C_PIPE_LAT   = 30,
    parameter int C_FIFO_DEPTH = 256,
    parameter int C_CNT_WIDTH  = 9,
    parameter int C_BEAT_BYTES = 16,
    parameter int C_LEN_WIDTH  = 23
) (
    input  logic        m_axi_mm2s_aclk,
    input  logic        rst,
    input  logic        enable,
    input  logic        in_tvalid,
    input  logic        in_tlast,
    output logic        in_tready,
    output logic        issue,
    output logic        res_wr,
    output logic        res_last,
    input  logic        rf_empty,
    input  logic        rf_last,
    output logic        rf_rd,
    output logic        s2mm_tvalid,
    input  logic        s2mm_tready,
    output logic [31:0] sts_tdata,
    output logic [3:0]  sts_tkeep,
    output logic        sts_tvalid,
    output logic        sts_tlast,
    input  logic        sts_tready,
    output logic        busy
);

    localparam logic [C_CNT_WIDTH-1:0] CREDIT_MAX =
        C_CNT_WIDTH'(C_FIFO_DEPTH);
    localparam logic [C_LEN_WIDTH:0] LEN_MAX =
        {1'b0, {C_LEN_WIDTH{1'b1}}};
    localparam logic [C_LEN_WIDTH:0] BEAT_INC =
        (C_LEN_WIDTH+1)'(C_BEAT_BYTES);
    localparam logic [STS_IDX_W-1:0] LAST_IDX =
        STS_IDX_W'(STS_NWORDS - 1);

    logic [C_CNT_WIDTH-1:0] credit_q;
    logic [1:0]             pipe_d;
    logic [1:0]             pipe_q;
    logic                   pipe_any;

    sched_state_t           state_q;
    sched_state_t           state_d;
    logic [STS_IDX_W-1:0]   idx_q;
    logic [STS_IDX_W-1:0]   idx_d;
    logic [C_LEN_WIDTH-1:0] cnt_q;
    logic [C_LEN_WIDTH-1:0] cnt_d;
    logic [C_LEN_WIDTH-1:0] len_q;
    logic [C_LEN_WIDTH-1:0] len_d;
    logic [C_LEN_WIDTH:0]   cnt_sum;
    logic [C_LEN_WIDTH-1:0] cnt_sat;

    // Issue path: a free FIFO slot is reserved at issue time.
    assign in_tready = enable & (credit_q != '0);
    assign issue     = in_tvalid & in_tready;

    always_ff @(posedge m_axi_mm2s_aclk or posedge rst) begin
        if (rst) begin
            credit_q <= CREDIT_MAX;
        end else begin
            case ({issue, rf_rd})
                2'b10:   credit_q <= credit_q - 1'b1;
                2'b01:   credit_q <= credit_q + 1'b1;
                default: credit_q <= credit_q;
            endcase
        end
    end

    // Beat flags follow the data through the AES latency.
    assign pipe_d = {issue, in_tlast & issue};

    aes_lat_pipe #(
        .W   (2),
        .LAT (C_PIPE_LAT)
    ) u_lat_pipe (
        .clk (m_axi_mm2s_aclk),
        .rst (rst),
        .d   (pipe_d),
        .q   (pipe_q),
        .any (pipe_any)
    );

    assign res_wr   = pipe_q[1];
    assign res_last = pipe_q[0];

    // Byte count saturates rather than wrapping on oversize packets.
    assign cnt_sum = {1'b0, cnt_q} + BEAT_INC;
    assign cnt_sat = (cnt_sum > LEN_MAX) ? {C_LEN_WIDTH{1'b1}}
                                         : cnt_sum[C_LEN_WIDTH-1:0];

    always_ff @(posedge m_axi_mm2s_aclk or posedge rst) begin
        if (rst) begin
            state_q <= ST_DATA;
            idx_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        s2mm_tvalid = 1'b0;
        rf_rd       = 1'b0;
        sts_tvalid  = 1'b0;
        sts_tlast   = 1'b0;
        sts_tdata   = '0;
        unique case (state_q)
            ST_DATA: begin
                s2mm_tvalid = ~rf_empty;
                rf_rd       = ~rf_empty & s2mm_tready;
                if (rf_rd) begin
                    if (rf_last) begin
                        len_d   = cnt_sat;
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = ST_STS;
                    end else begin
                        cnt_d = cnt_sat;
                    end
                end
            end
            ST_STS: begin
                sts_tvalid = 1'b1;
                sts_tlast  = (idx_q == LAST_IDX);
                unique case (1'b1)
                    (idx_q == '0):       sts_tdata = STS_WORD0;
                    (idx_q == LAST_IDX): sts_tdata = 32'(len_q);
                    default:             sts_tdata = '0;
                endcase
                if (sts_tready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DATA;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_DATA;
        endcase
    end

    assign sts_tkeep = 4'hf;
    assign busy      = pipe_any | ~rf_empty | (state_q == ST_STS);

    a_credit_no_overflow: assert property (
        @(posedge m_axi_mm2s_aclk) disable iff (rst)
        (rf_rd && !issue) |-> (credit_q != CREDIT_MAX)
    );

    a_credit_no_underflow: assert property (
        @(posedge m_axi_mm2s_aclk) disable iff (rst)
        (issue && !rf_rd) |-> (credit_q != '0)
    );

endmodule
